baccarat_round_fsm: RTL and testbench

//  Round controller for the baccarat datapath; sits directly upstream of the card registers feeding scorehand.

---
 rtl/baccarat_round_if.sv | 32 +++
 rtl/baccarat_round_fsm.sv | 129 ++++++++++++
 tb/tb_baccarat_round_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/baccarat_round_if.sv
// Round-controller bus: step/score inputs from the datapath, load strobes and result lights back.
interface baccarat_round_if;
    localparam int unsigned SCORE_W = 4;

    logic               step;
    logic [SCORE_W-1:0] pscore;
    logic [SCORE_W-1:0] dscore;
    logic [SCORE_W-1:0] pcard3;
    logic               load_pcard1;
    logic               load_pcard2;
    logic               load_pcard3;
    logic               load_dcard1;
    logic               load_dcard2;
    logic               load_dcard3;
    logic               player_win_light;
    logic               dealer_win_light;
    logic               done;

    modport master (
        output step, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, done
    );

    modport slave (
        input  step, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, done
    );
endinterface

// File: rtl/baccarat_round_fsm.sv
// Baccarat round controller: sequences card loads, applies natural/third-card rules, latches winner lights.
module baccarat_round_fsm #(
    parameter int unsigned NATURAL_MIN     = 8,
    parameter int unsigned PLAYER_DRAW_MAX = 5,
    parameter int unsigned DEALER_DRAW_MAX = 5
) (
    input  logic             slow_clock,
    input  logic             reset,
    baccarat_round_if.slave  bus
);
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned STROBE_W = 6;

    typedef enum logic [STATE_W-1:0] {
        IDLE, LP1, W1, LD1, W2, LP2, W3, LD2,
        EVAL, W4, LP3, EVAL_B, W5, LD3, CMP, DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [STROBE_W-1:0]   strobes_q;
    logic [STROBE_W-1:0]   strobes_d;
    logic                  player_light_q;
    logic                  player_light_d;
    logic                  dealer_light_q;
    logic                  dealer_light_d;
    logic                  done_q;
    logic                  done_d;
    logic [3:0]            v;
    logic                  natural;
    logic                  dealer_draw;

    // Face cards and tens count as zero for the dealer table
    always_comb begin
        v           = (bus.pcard3 <= 4'd9) ? bus.pcard3 : 4'd0;
        natural     = (bus.pscore >= 4'(NATURAL_MIN)) || (bus.dscore >= 4'(NATURAL_MIN));
        dealer_draw = 1'b0;
        case (bus.dscore)
            4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
            4'd3:             dealer_draw = (v != 4'd8);
            4'd4:             dealer_draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             dealer_draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             dealer_draw = (v >= 4'd6) && (v <= 4'd7);
            default:          dealer_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (bus.step) state_next = LP1;
            LP1:    state_next = W1;
            W1:     if (bus.step) state_next = LD1;
            LD1:    state_next = W2;
            W2:     if (bus.step) state_next = LP2;
            LP2:    state_next = W3;
            W3:     if (bus.step) state_next = LD2;
            LD2:    state_next = EVAL;
            EVAL: begin
                if (natural)                                    state_next = CMP;
                else if (bus.pscore <= 4'(PLAYER_DRAW_MAX))     state_next = W4;
                else if (bus.dscore <= 4'(DEALER_DRAW_MAX))     state_next = W5;
                else                                            state_next = CMP;
            end
            W4:     if (bus.step) state_next = LP3;
            LP3:    state_next = EVAL_B;
            EVAL_B: state_next = dealer_draw ? W5 : CMP;
            W5:     if (bus.step) state_next = LD3;
            LD3:    state_next = CMP;
            CMP:    state_next = DONE;
            DONE:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobe lines up with the load state
    always_comb begin
        strobes_d      = '0;
        done_d         = 1'b0;
        player_light_d = player_light_q;
        dealer_light_d = dealer_light_q;
        case (state_next)
            LP1:     strobes_d[0] = 1'b1;
            LD1:     strobes_d[1] = 1'b1;
            LP2:     strobes_d[2] = 1'b1;
            LD2:     strobes_d[3] = 1'b1;
            LP3:     strobes_d[4] = 1'b1;
            LD3:     strobes_d[5] = 1'b1;
            DONE:    done_d       = 1'b1;
            default: strobes_d    = '0;
        endcase
        if (state == CMP) begin
            player_light_d = (bus.pscore >= bus.dscore);
            dealer_light_d = (bus.dscore >= bus.pscore);
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            strobes_q      <= '0;
            player_light_q <= 1'b0;
            dealer_light_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            strobes_q      <= strobes_d;
            player_light_q <= player_light_d;
            dealer_light_q <= dealer_light_d;
            done_q         <= done_d;
        end
    end

    assign bus.load_pcard1      = strobes_q[0];
    assign bus.load_dcard1      = strobes_q[1];
    assign bus.load_pcard2      = strobes_q[2];
    assign bus.load_dcard2      = strobes_q[3];
    assign bus.load_pcard3      = strobes_q[4];
    assign bus.load_dcard3      = strobes_q[5];
    assign bus.player_win_light = player_light_q;
    assign bus.dealer_win_light = dealer_light_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Self-checking bench for baccarat_round_fsm: directed scenarios plus random rounds against a rule-level model.
module tb_baccarat_round_fsm;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    baccarat_round_if bif ();

    baccarat_round_fsm dut (
        .slow_clock (clk),
        .reset      (reset),
        .bus        (bif.slave)
    );

    // Strobe code per cycle: 0 none, 1 P1, 2 D1, 3 P2, 4 D2, 5 P3, 6 D3, 7 illegal combination
    function automatic logic [2:0] strobe_code();
        logic [5:0] m;
        m = {bif.load_dcard3, bif.load_pcard3, bif.load_dcard2,
             bif.load_pcard2, bif.load_dcard1, bif.load_pcard1};
        if (m == 6'd0) return 3'd0;
        case (m)
            6'b000001: return 3'd1;
            6'b000010: return 3'd2;
            6'b000100: return 3'd3;
            6'b001000: return 3'd4;
            6'b010000: return 3'd5;
            6'b100000: return 3'd6;
            default:   return 3'd7;
        endcase
    endfunction

    function automatic logic [8:0] all_outs();
        return {bif.load_dcard3, bif.load_pcard3, bif.load_dcard2, bif.load_pcard2,
                bif.load_dcard1, bif.load_pcard1, bif.player_win_light,
                bif.dealer_win_light, bif.done};
    endfunction

    // Rule-level model of one round: card sequence as octal digits and final lights
    function automatic void exp_round(input logic [3:0] ps0, input logic [3:0] ds0,
                                      input logic [3:0] c3, input logic [3:0] ps1,
                                      input logic [3:0] ds1, output logic [31:0] code,
                                      output logic [1:0] lights);
        logic [3:0] p, d, val;
        bit pdraw, ddraw;
        p = ps0; d = ds0; pdraw = 0; ddraw = 0;
        code = 32'o1234;
        if (ps0 < 4'd8 && ds0 < 4'd8) begin
            if (ps0 <= 4'd5) begin
                pdraw = 1;
                val = (c3 > 4'd9) ? 4'd0 : c3;
                case (ds0)
                    4'd0, 4'd1, 4'd2: ddraw = 1;
                    4'd3: ddraw = (val != 4'd8);
                    4'd4: ddraw = (val >= 4'd2 && val <= 4'd7);
                    4'd5: ddraw = (val >= 4'd4 && val <= 4'd7);
                    4'd6: ddraw = (val == 4'd6 || val == 4'd7);
                    default: ddraw = 0;
                endcase
            end else begin
                ddraw = (ds0 <= 4'd5);
            end
        end
        if (pdraw) begin code = (code << 3) | 32'd5; p = ps1; end
        if (ddraw) begin code = (code << 3) | 32'd6; d = ds1; end
        lights = {p >= d, d >= p};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        bif.step = 1'($urandom_range(0, 1));
        @(negedge clk);
        reset    = 1'b0;
        bif.step = 1'b0;
    endtask

    // Sample first, then drive step[i] for the following cycle
    task automatic run_cycles(input int n, input logic [31:0] pat, input logic [31:0] code_in,
                              output logic [31:0] code_out);
        logic [2:0] c;
        code_out = code_in;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c = strobe_code();
            if (c != 3'd0) code_out = {code_out[28:0], c};
            bif.step = pat[i];
        end
    endtask

    // Play one round with random step spacing; scores change when the third cards are loaded
    task automatic do_round(input logic [3:0] ps0, input logic [3:0] ds0, input logic [3:0] c3,
                            input logic [3:0] ps1, input logic [3:0] ds1,
                            output logic [31:0] code, output logic [1:0] lights,
                            output logic dn, output bit to);
        int gap, after;
        bit seen;
        logic [2:0] c;
        bif.pscore = ps0; bif.dscore = ds0; bif.pcard3 = c3; bif.step = 1'b0;
        apply_reset();
        code = '0; to = 1; after = 0; seen = 0; gap = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            c = strobe_code();
            if (c != 3'd0) code = {code[28:0], c};
            if (bif.load_pcard3) bif.pscore = ps1;
            if (bif.load_dcard3) bif.dscore = ds1;
            if (bif.done) seen = 1;
            if (seen) begin
                after++;
                if (after == 5) begin to = 0; break; end
            end
            if (gap == 0) begin bif.step = 1'b1; gap = $urandom_range(1, 3); end
            else begin bif.step = 1'b0; gap--; end
        end
        bif.step = 1'b0;
        lights = {bif.player_win_light, bif.dealer_win_light};
        dn = bif.done;
    endtask

    task automatic test_reset();
        bif.pscore = 4'd3; bif.dscore = 4'd4; bif.pcard3 = 4'd2;
        @(negedge clk);
        reset = 1'b1; bif.step = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_outs() !== 9'd0) begin
            n_bad++; $display("FAIL reset_outs: got %b want %b", all_outs(), 9'd0);
        end
        reset = 1'b0; bif.step = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (all_outs() !== 9'd0) begin
            n_bad++; $display("FAIL reset_idle: got %b want %b", all_outs(), 9'd0);
        end
    endtask

    task automatic test_natural();
        logic [31:0] code; logic [1:0] l; logic dn; bit to;
        do_round(4'd8, 4'd3, 4'd5, 4'd0, 4'd0, code, l, dn, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL natural_timeout: done never seen"); end
        n_cmp++; if (code !== 32'o1234) begin n_bad++; $display("FAIL natural_seq: got %o want %o", code, 32'o1234); end
        n_cmp++; if (l !== 2'b10) begin n_bad++; $display("FAIL natural_lights: got %b want %b", l, 2'b10); end
        n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL natural_done: got %b want 1", dn); end
    endtask

    task automatic test_player_draw();
        logic [31:0] code; logic [1:0] l; logic dn; bit to;
        do_round(4'd4, 4'd7, 4'd5, 4'd9, 4'd0, code, l, dn, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL pdraw_timeout: done never seen"); end
        n_cmp++; if (code !== 32'o12345) begin n_bad++; $display("FAIL pdraw_seq: got %o want %o", code, 32'o12345); end
        n_cmp++; if (l !== 2'b10) begin n_bad++; $display("FAIL pdraw_lights: got %b want %b", l, 2'b10); end
    endtask

    task automatic test_dealer_table();
        logic [31:0] code; logic [1:0] l; logic dn; bit to;
        logic [3:0]  c3s  [2] = '{4'd7, 4'd5};
        logic [3:0]  ps1s [2] = '{4'd9, 4'd7};
        logic [31:0] want [2] = '{32'o123456, 32'o12345};
        for (int k = 0; k < 2; k++) begin
            do_round(4'd2, 4'd6, c3s[k], ps1s[k], 4'd1, code, l, dn, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL dtable_timeout[%0d]: done never seen", k); end
            n_cmp++; if (code !== want[k]) begin n_bad++; $display("FAIL dtable_seq[%0d]: got %o want %o", k, code, want[k]); end
            n_cmp++; if (l !== 2'b10) begin n_bad++; $display("FAIL dtable_lights[%0d]: got %b want %b", k, l, 2'b10); end
        end
    endtask

    task automatic test_face_card();
        logic [31:0] code; logic [1:0] l; logic dn; bit to;
        logic [3:0]  c3s  [2] = '{4'd12, 4'd8};
        logic [31:0] want [2] = '{32'o123456, 32'o12345};
        logic [1:0]  wl   [2] = '{2'b01, 2'b10};
        for (int k = 0; k < 2; k++) begin
            do_round(4'd1, 4'd3, c3s[k], 4'd4, 4'd5, code, l, dn, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL face_timeout[%0d]: done never seen", k); end
            n_cmp++; if (code !== want[k]) begin n_bad++; $display("FAIL face_seq[%0d]: got %o want %o", k, code, want[k]); end
            n_cmp++; if (l !== wl[k]) begin n_bad++; $display("FAIL face_lights[%0d]: got %b want %b", k, l, wl[k]); end
        end
    endtask

    task automatic test_player_stands();
        logic [31:0] code; logic [1:0] l; logic dn; bit to;
        do_round(4'd7, 4'd5, 4'd0, 4'd0, 4'd7, code, l, dn, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL pstand_timeout: done never seen"); end
        n_cmp++; if (code !== 32'o12346) begin n_bad++; $display("FAIL pstand_seq: got %o want %o", code, 32'o12346); end
        n_cmp++; if (l !== 2'b11) begin n_bad++; $display("FAIL pstand_tie: got %b want %b", l, 2'b11); end
    endtask

    task automatic test_step_hold();
        logic [31:0] code;
        bif.pscore = 4'd1; bif.dscore = 4'd1; bif.pcard3 = 4'd0;
        apply_reset();
        run_cycles(8, 32'b0000_0011, 32'd0, code);
        n_cmp++; if (code !== 32'o1) begin n_bad++; $display("FAIL hold_single: got %o want %o", code, 32'o1); end
        run_cycles(5, 32'b00001, code, code);
        n_cmp++; if (code !== 32'o12) begin n_bad++; $display("FAIL hold_next: got %o want %o", code, 32'o12); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] code;
        bif.pscore = 4'd1; bif.dscore = 4'd1; bif.pcard3 = 4'd0;
        apply_reset();
        run_cycles(9, 32'b0_0100_1001, 32'd0, code);
        n_cmp++; if (code !== 32'o123) begin n_bad++; $display("FAIL midrst_pre: got %o want %o", code, 32'o123); end
        reset = 1'b1; bif.step = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (all_outs() !== 9'd0) begin n_bad++; $display("FAIL midrst_outs: got %b want %b", all_outs(), 9'd0); end
        bif.step = 1'b1;
        @(negedge clk);
        bif.step = 1'b0;
        n_cmp++; if (all_outs() !== 9'b000001_000) begin n_bad++; $display("FAIL midrst_restart: got %b want %b", all_outs(), 9'b000001_000); end
    endtask

    task automatic test_random();
        logic [31:0] code, ecode; logic [1:0] l, el; logic dn; bit to;
        logic [3:0] ps0, ds0, c3, ps1, ds1;
        for (int r = 0; r < 40; r++) begin
            ps0 = 4'($urandom_range(0, 9)); ds0 = 4'($urandom_range(0, 9));
            c3  = 4'($urandom_range(0, 13));
            ps1 = 4'($urandom_range(0, 9)); ds1 = 4'($urandom_range(0, 9));
            exp_round(ps0, ds0, c3, ps1, ds1, ecode, el);
            do_round(ps0, ds0, c3, ps1, ds1, code, l, dn, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rand_timeout[%0d]: done never seen", r); end
            n_cmp++;
            if (code !== ecode || l !== el || dn !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_round[%0d] p=%0d d=%0d c3=%0d p1=%0d d1=%0d: got seq %o lights %b done %b want seq %o lights %b done 1",
                         r, ps0, ds0, c3, ps1, ds1, code, l, dn, ecode, el);
            end
        end
    endtask

    initial begin
        reset = 1'b1; bif.step = 1'b0;
        bif.pscore = '0; bif.dscore = '0; bif.pcard3 = '0;
        test_reset();
        test_natural();
        test_player_draw();
        test_dealer_table();
        test_face_card();
        test_player_stands();
        test_step_hold();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
